// File: rtl/mastermind_scorer.sv
// Mastermind guess scorer: latches a 4-slot code, scores guesses, tracks win/lose.
// Optional SCORER_HINT_EN adds a per-slot exact-match hint_mask output.
module mastermind_scorer #(
    parameter int MAX_GUESSES = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_load,
    input  logic [1:0]       code3,
    input  logic [1:0]       code2,
    input  logic [1:0]       code1,
    input  logic [1:0]       code0,
    input  logic             guess_valid,
    input  logic [1:0]       guess3,
    input  logic [1:0]       guess2,
    input  logic [1:0]       guess1,
    input  logic [1:0]       guess0,
    output logic             ready,
    output logic             score_valid,
    output logic [2:0]       exact,
    output logic [2:0]       partial,
    output logic [CNT_W-1:0] guesses_used,
    output logic             win,
`ifdef SCORER_HINT_EN
    output logic [3:0]       hint_mask,
`endif
    output logic             lose
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CMP,
        CNT,
        DONE
    } state_t;

    state_t           state_q;
    logic [3:0][1:0]  code_q;
    logic [3:0][1:0]  guess_q;
    logic [2:0]       cmp_exact_q;
    logic [2:0]       exact_q;
    logic [2:0]       partial_q;
    logic [CNT_W-1:0] used_q;
    logic             score_valid_q;
    logic             win_q;
    logic             lose_q;

    logic [3:0]       slot_eq;
    logic [2:0]       exact_d;
    logic [2:0]       partial_d;
    logic [2:0]       sum_min;
    logic [CNT_W-1:0] used_d;

`ifdef SCORER_HINT_EN
    logic [3:0] cmp_hint_q;
    logic [3:0] hint_q;
    assign hint_mask = hint_q;
`endif

    always_comb begin
        slot_eq = '0;
        exact_d = '0;
        sum_min = '0;
        for (int i = 0; i < 4; i++) begin
            slot_eq[i] = (guess_q[i] == code_q[i]);
            exact_d    = exact_d + {2'b00, slot_eq[i]};
        end
        // Colour matches regardless of position, then remove the exact ones
        for (int c = 0; c < 4; c++) begin : g_tally
            logic [2:0] nc;
            logic [2:0] ng;
            nc = '0;
            ng = '0;
            for (int i = 0; i < 4; i++) begin
                nc = nc + {2'b00, (code_q[i] == 2'(c))};
                ng = ng + {2'b00, (guess_q[i] == 2'(c))};
            end
            sum_min = sum_min + ((nc < ng) ? nc : ng);
        end
        partial_d = sum_min - cmp_exact_q;
        used_d    = (used_q == CNT_W'(MAX_GUESSES)) ? used_q : used_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            code_q        <= '0;
            guess_q       <= '0;
            cmp_exact_q   <= '0;
            exact_q       <= '0;
            partial_q     <= '0;
            used_q        <= '0;
            score_valid_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
`ifdef SCORER_HINT_EN
            cmp_hint_q    <= '0;
            hint_q        <= '0;
`endif
        end else begin
            score_valid_q <= 1'b0;
            if (code_load) begin
                state_q   <= ARMED;
                code_q    <= {code3, code2, code1, code0};
                exact_q   <= '0;
                partial_q <= '0;
                used_q    <= '0;
                win_q     <= 1'b0;
                lose_q    <= 1'b0;
`ifdef SCORER_HINT_EN
                hint_q    <= '0;
`endif
            end else begin
                unique case (state_q)
                    IDLE: ;
                    ARMED: begin
                        if (guess_valid) begin
                            guess_q <= {guess3, guess2, guess1, guess0};
                            state_q <= CMP;
                        end
                    end
                    CMP: begin
                        cmp_exact_q <= exact_d;
`ifdef SCORER_HINT_EN
                        cmp_hint_q  <= slot_eq;
`endif
                        state_q     <= CNT;
                    end
                    CNT: begin
                        exact_q       <= cmp_exact_q;
                        partial_q     <= partial_d;
                        score_valid_q <= 1'b1;
                        used_q        <= used_d;
`ifdef SCORER_HINT_EN
                        hint_q        <= cmp_hint_q;
`endif
                        if (cmp_exact_q == 3'd4) begin
                            win_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (used_d == CNT_W'(MAX_GUESSES)) begin
                            lose_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= ARMED;
                        end
                    end
                    DONE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ready        = (state_q == ARMED);
    assign score_valid  = score_valid_q;
    assign exact        = exact_q;
    assign partial      = partial_q;
    assign guesses_used = used_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed self-checking bench for mastermind_scorer (MAX_GUESSES=3).
// Observed outputs are packed as {score_valid,ready,exact,partial,used,win,lose}.
module tb_mastermind_scorer;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_load;
    logic [1:0] code3, code2, code1, code0;
    logic       guess_valid;
    logic [1:0] guess3, guess2, guess1, guess0;
    logic       ready, score_valid, win, lose;
    logic [2:0] exact, partial;
    logic [3:0] guesses_used;
`ifdef SCORER_HINT_EN
    logic [3:0] hint_mask;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mastermind_scorer #(.MAX_GUESSES(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .code_load(code_load),
        .code3(code3), .code2(code2), .code1(code1), .code0(code0),
        .guess_valid(guess_valid),
        .guess3(guess3), .guess2(guess2), .guess1(guess1), .guess0(guess0),
        .ready(ready), .score_valid(score_valid),
        .exact(exact), .partial(partial), .guesses_used(guesses_used),
        .win(win),
`ifdef SCORER_HINT_EN
        .hint_mask(hint_mask),
`endif
        .lose(lose)
    );

    always #5 clk = ~clk;

    wire [13:0] obs = {score_valid, ready, exact, partial, guesses_used, win, lose};

    function automatic logic [13:0] ev(logic sv, logic rd, logic [2:0] ex,
                                       logic [2:0] pa, logic [3:0] us,
                                       logic w, logic l);
        return {sv, rd, ex, pa, us, w, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] c3, c2, c1, c0);
        {code3, code2, code1, code0} = {c3, c2, c1, c0};
        code_load = 1'b1;
        tick();
        code_load = 1'b0;
    endtask

    task automatic guess(input logic [1:0] g3, g2, g1, g0);
        {guess3, guess2, guess1, guess0} = {g3, g2, g1, g0};
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        code_load = 1'b0;
        guess_valid = 1'b0;
        {code3, code2, code1, code0} = '0;
        {guess3, guess2, guess1, guess0} = '0;
        #1;
        n_cmp++;
        if (obs !== 14'h0) begin
            n_err++;
            $display("FAIL reset_state got %h want %h", obs, 14'h0);
        end
        tick();
        tick();
        reset = 1'b1;
        guess_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (obs !== 14'h0) begin
                n_err++;
                $display("FAIL idle_guess_ignored cyc %0d got %h want %h", i, obs, 14'h0);
            end
        end
        guess_valid = 1'b0;
    endtask

    task automatic test_win();
        load(3, 1, 2, 0);
        n_cmp++;
        if (obs !== ev(0, 1, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL win_armed got %h want %h", obs, ev(0, 1, 0, 0, 0, 0, 0));
        end
        guess(3, 1, 2, 0);
        tick();
        n_cmp++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL win_latency got %h want %h", obs, ev(0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        n_cmp++;
        if (obs !== ev(1, 0, 4, 0, 1, 1, 0)) begin
            n_err++;
            $display("FAIL win_score got %h want %h", obs, ev(1, 0, 4, 0, 1, 1, 0));
        end
        tick();
        n_cmp++;
        if (obs !== ev(0, 0, 4, 0, 1, 1, 0)) begin
            n_err++;
            $display("FAIL win_hold got %h want %h", obs, ev(0, 0, 4, 0, 1, 1, 0));
        end
    endtask

    task automatic test_partial();
        load(3, 1, 2, 0);
        n_cmp++;
        if (obs !== ev(0, 1, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reload_clear got %h want %h", obs, ev(0, 1, 0, 0, 0, 0, 0));
        end
        guess(0, 2, 1, 3);
        tick();
        tick();
        n_cmp++;
        if (obs !== ev(1, 1, 0, 4, 1, 0, 0)) begin
            n_err++;
            $display("FAIL partial4 got %h want %h", obs, ev(1, 1, 0, 4, 1, 0, 0));
        end
`ifdef SCORER_HINT_EN
        n_cmp++;
        if (hint_mask !== 4'b0000) begin
            n_err++;
            $display("FAIL hint_none got %b want %b", hint_mask, 4'b0000);
        end
`endif
        guess(3, 3, 3, 3);
        tick();
        tick();
        n_cmp++;
        if (obs !== ev(1, 1, 1, 0, 2, 0, 0)) begin
            n_err++;
            $display("FAIL exact1 got %h want %h", obs, ev(1, 1, 1, 0, 2, 0, 0));
        end
`ifdef SCORER_HINT_EN
        n_cmp++;
        if (hint_mask !== 4'b1000) begin
            n_err++;
            $display("FAIL hint_slot3 got %b want %b", hint_mask, 4'b1000);
        end
`endif
    endtask

    task automatic test_lose();
        load(1, 1, 0, 0);
        guess(1, 0, 0, 2);
        tick();
        tick();
        n_cmp++;
        if (obs !== ev(1, 1, 2, 1, 1, 0, 0)) begin
            n_err++;
            $display("FAIL lose_g1 got %h want %h", obs, ev(1, 1, 2, 1, 1, 0, 0));
        end
        guess(0, 0, 1, 1);
        tick();
        tick();
        n_cmp++;
        if (obs !== ev(1, 1, 0, 4, 2, 0, 0)) begin
            n_err++;
            $display("FAIL lose_g2 got %h want %h", obs, ev(1, 1, 0, 4, 2, 0, 0));
        end
        guess(2, 2, 2, 2);
        tick();
        tick();
        n_cmp++;
        if (obs !== ev(1, 0, 0, 0, 3, 0, 1)) begin
            n_err++;
            $display("FAIL lose_g3 got %h want %h", obs, ev(1, 0, 0, 0, 3, 0, 1));
        end
        {guess3, guess2, guess1, guess0} = 8'h00;
        guess_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (obs !== ev(0, 0, 0, 0, 3, 0, 1)) begin
                n_err++;
                $display("FAIL lose_extra cyc %0d got %h want %h", i, obs, ev(0, 0, 0, 0, 3, 0, 1));
            end
        end
        guess_valid = 1'b0;
    endtask

    task automatic test_code_load_abort();
        load(3, 1, 2, 0);
        guess(3, 3, 3, 3);
        tick();
        tick();
        n_cmp++;
        if (obs !== ev(1, 1, 1, 0, 1, 0, 0)) begin
            n_err++;
            $display("FAIL abort_pre got %h want %h", obs, ev(1, 1, 1, 0, 1, 0, 0));
        end
        {guess3, guess2, guess1, guess0} = 8'h00;
        guess_valid = 1'b1;
        load(0, 0, 0, 0);
        guess_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs !== ev(0, 1, 0, 0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL coincident_load cyc %0d got %h want %h", i, obs, ev(0, 1, 0, 0, 0, 0, 0));
            end
            tick();
        end
        guess(1, 1, 1, 1);
        load(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs !== ev(0, 1, 0, 0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL cmp_load cyc %0d got %h want %h", i, obs, ev(0, 1, 0, 0, 0, 0, 0));
            end
            tick();
        end
        guess(1, 1, 1, 1);
        tick();
        tick();
        n_cmp++;
        if (obs !== ev(1, 0, 4, 0, 1, 1, 0)) begin
            n_err++;
            $display("FAIL new_code got %h want %h", obs, ev(1, 0, 4, 0, 1, 1, 0));
        end
    endtask

    task automatic test_reset_in_cnt();
        load(3, 1, 2, 0);
        guess(3, 3, 3, 3);
        tick();
        tick();
        guess(3, 1, 2, 0);
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 14'h0) begin
            n_err++;
            $display("FAIL async_reset got %h want %h", obs, 14'h0);
        end
`ifdef SCORER_HINT_EN
        n_cmp++;
        if (hint_mask !== 4'b0000) begin
            n_err++;
            $display("FAIL hint_reset got %b want %b", hint_mask, 4'b0000);
        end
`endif
        tick();
        reset = 1'b1;
        guess_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs !== 14'h0) begin
                n_err++;
                $display("FAIL post_reset_idle cyc %0d got %h want %h", i, obs, 14'h0);
            end
        end
        guess_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_win();
        test_partial();
        test_lose();
        test_code_load_abort();
        test_reset_in_cnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
